// File: rtl/pdn_pkg.sv
// Shared types and default sizes for the PuDianNao accumulator feed path.
package pdn_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_LEN_W = 16;

    // Vector framing state: IDLE waits for element 0, RUN walks the remaining elements.
    typedef enum logic {
        FEED_IDLE = 1'b0,
        FEED_RUN  = 1'b1
    } feed_state_t;

endpackage

// File: rtl/pdn_mul_pipe.sv
// Two-stage signed multiplier with a shared enable and a valid/first/last sideband
// that travels in lockstep with the operands.
module pdn_mul_pipe
    import pdn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_first,
    input  logic                 in_last,
    output logic                 out_valid,
    output logic [2*WIDTH-1:0]   out_prod,
    output logic                 out_first,
    output logic                 out_last
);

    localparam int PW = 2 * WIDTH;

    logic                    s1_valid;
    logic                    s1_first;
    logic                    s1_last;
    logic signed [WIDTH-1:0] s1_a;
    logic signed [WIDTH-1:0] s1_b;

    logic                    s2_valid;
    logic                    s2_first;
    logic                    s2_last;
    logic signed [PW-1:0]    s2_prod;

    // Stage 1: capture the operand pair; tags are only set for a real beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_first <= in_valid && in_first;
            s1_last  <= in_valid && in_last;
            s1_a     <= in_a;
            s1_b     <= in_b;
        end
    end

    // Stage 2: full-width signed product, operands sign-extended before the multiply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_first <= 1'b0;
            s2_last  <= 1'b0;
            s2_prod  <= '0;
        end else if (en) begin
            s2_valid <= s1_valid;
            s2_first <= s1_first;
            s2_last  <= s1_last;
            s2_prod  <= PW'(s1_a) * PW'(s1_b);
        end
    end

    assign out_valid = s2_valid;
    assign out_first = s2_first;
    assign out_last  = s2_last;
    assign out_prod  = s2_prod;

endmodule

// File: rtl/acc_feed_mul.sv
// Accumulator feed stage: multiplies streamed operand pairs and frames each vector with
// first/last tags that drive the accumulator clear/stop controls.
module acc_feed_mul
    import pdn_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int SAT   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [LEN_W-1:0] vec_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_first,
    output logic             out_last,
    output logic             vec_done
);

    localparam int PW = 2 * WIDTH;

    // Handshake: a beat moves on a side when valid && ready there. Once out_valid is high it
    // stays high with data/tags frozen until out_ready; that stall freezes the whole pipe and
    // the framing counter, and in_ready is simply !stall so nothing enters a frozen pipe.
    logic stall;
    logic pipe_en;
    logic accept;

    feed_state_t      state;
    feed_state_t      state_nxt;
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] len_nxt;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] cnt_nxt;
    logic [LEN_W-1:0] len_eff;
    logic             tag_first;
    logic             tag_last;

    logic [PW-1:0]    prod;
    logic [PW-WIDTH:0] prod_hi;
    logic             prod_ovf;

    assign stall    = out_valid && !out_ready;
    assign pipe_en  = !stall;
    assign in_ready = pipe_en;
    assign accept   = in_valid && in_ready;

    // A zero length is treated as a single-element vector.
    assign len_eff = (vec_len == '0) ? LEN_W'(1) : vec_len;

    // Framing state, latched length and element counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FEED_IDLE;
            len   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            len   <= len_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state and beat tagging; only an accepted input beat advances the framing.
    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        cnt_nxt   = cnt;
        tag_first = 1'b0;
        tag_last  = 1'b0;
        case (state)
            FEED_IDLE: begin
                tag_first = 1'b1;
                tag_last  = (len_eff == LEN_W'(1));
                if (accept) begin
                    len_nxt = len_eff;
                    if (!tag_last) begin
                        cnt_nxt   = LEN_W'(1);
                        state_nxt = FEED_RUN;
                    end
                end
            end
            FEED_RUN: begin
                tag_last = (cnt == len - LEN_W'(1));
                if (accept) begin
                    if (tag_last) begin
                        cnt_nxt   = '0;
                        state_nxt = FEED_IDLE;
                    end else begin
                        cnt_nxt = cnt + LEN_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = FEED_IDLE;
            end
        endcase
    end

    pdn_mul_pipe #(
        .WIDTH(WIDTH)
    ) u_mul_pipe (
        .clk      (clk),
        .rst      (rst),
        .en       (pipe_en),
        .in_valid (accept),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_first (tag_first),
        .in_last  (tag_last),
        .out_valid(out_valid),
        .out_prod (prod),
        .out_first(out_first),
        .out_last (out_last)
    );

    // The product fits in WIDTH signed bits exactly when its top WIDTH+1 bits all agree.
    assign prod_hi  = prod[PW-1:WIDTH-1];
    assign prod_ovf = !((&prod_hi) || !(|prod_hi));

    // Output mux: wrap to the low bits, or clamp to the signed range when saturating.
    always_comb begin
        out_data = prod[WIDTH-1:0];
        if (SAT != 0 && prod_ovf) begin
            out_data = prod[PW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    assign vec_done = out_valid && out_ready && out_last;

endmodule

// File: tb/tb_acc_feed_mul.sv
// Bench for acc_feed_mul: a wrapping and a saturating instance share one stimulus stream;
// expected products and framing come from plain 64-bit arithmetic and vector indices.
module tb_acc_feed_mul;

    localparam int W  = 32;
    localparam int LW = 16;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [LW-1:0] vec_len = '0;

    logic          in_ready_w, out_valid_w, out_first_w, out_last_w, vec_done_w;
    logic [W-1:0]  out_data_w;
    logic          in_ready_s, out_valid_s, out_first_s, out_last_s, vec_done_s;
    logic [W-1:0]  out_data_s;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    bit bp_mode = 1'b0;
    bit force_stall = 1'b0;
    always @(posedge clk) begin
        #1;
        out_ready = bp_mode ? ($urandom_range(0, 3) != 0) : !force_stall;
    end

    acc_feed_mul #(.WIDTH(W), .LEN_W(LW), .SAT(0)) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_a(in_a), .in_b(in_b), .vec_len(vec_len),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .out_first(out_first_w), .out_last(out_last_w), .vec_done(vec_done_w)
    );

    acc_feed_mul #(.WIDTH(W), .LEN_W(LW), .SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_a(in_a), .in_b(in_b), .vec_len(vec_len),
        .out_valid(out_valid_s), .out_ready(out_ready), .out_data(out_data_s),
        .out_first(out_first_s), .out_last(out_last_s), .vec_done(vec_done_s)
    );

    // ---------------- scoreboard ----------------
    typedef struct {
        logic [W-1:0] wrap;
        logic [W-1:0] sat;
        logic         first;
        logic         last;
        int           cyc;
        bit           lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact 64-bit product, then wrap or clamp to the 32-bit signed range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit f, input bit l);
        exp_t   e;
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        e.wrap = p[W-1:0];
        if (p > 64'sd2147483647)       e.sat = 32'h7FFF_FFFF;
        else if (p < -64'sd2147483648) e.sat = 32'h8000_0000;
        else                           e.sat = p[W-1:0];
        e.first = f;
        e.last  = l;
        e.cyc   = 0;
        e.lat   = 1'b0;
        return e;
    endfunction

    // Monitor: compares the queue head whenever a product is presented, pops on transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (vec_done_w) done_cnt++;
            if (out_valid_w && !out_ready) begin
                check("in_ready_stall_w", W'(in_ready_w), W'(0));
                check("in_ready_stall_s", W'(in_ready_s), W'(0));
            end
            if (out_valid_w || out_valid_s) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got data %h with nothing expected", out_data_w);
                end else begin
                    e = exp_q[0];
                    check("valid_w", W'(out_valid_w), W'(1));
                    check("valid_s", W'(out_valid_s), W'(1));
                    check("data_wrap", out_data_w, e.wrap);
                    check("data_sat", out_data_s, e.sat);
                    check("first_w", W'(out_first_w), W'(e.first));
                    check("first_s", W'(out_first_s), W'(e.first));
                    check("last_w", W'(out_last_w), W'(e.last));
                    check("last_s", W'(out_last_s), W'(e.last));
                    check("vec_done_w", W'(vec_done_w), W'(out_ready && e.last));
                    check("vec_done_s", W'(vec_done_s), W'(out_ready && e.last));
                    if (out_ready) begin
                        if (e.lat) check("latency", W'(cyc - e.cyc), W'(2));
                        void'(exp_q.pop_front());
                    end
                end
            end else begin
                check("idle_vec_done", W'(vec_done_w), W'(0));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [LW-1:0] vl,
                        input bit f, input bit l, input bit lat);
        bit   ok = 1'b0;
        int   n = 0;
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        vec_len  = vl;
        while (!ok && n < 500) begin
            @(negedge clk);
            if (in_ready_w && in_ready_s && !rst) begin
                ok    = 1'b1;
                e     = model(a, b, f, l);
                e.cyc = cyc;
                e.lat = lat;
                exp_q.push_back(e);
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stayed %b, required 1", in_ready_w);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFF_FFFF;
            1:       return 32'h8000_0000;
            2:       return $urandom;
            default: return W'($urandom_range(0, 200)) - W'(100);
        endcase
    endfunction

    // One vector: element i is first when i==0 and last when i==eff-1; vec_len on
    // later beats is junk that the framing must ignore.
    task automatic send_vec(input int vl, input bit lat, input bit gaps);
        int eff;
        eff = (vl == 0) ? 1 : vl;
        for (int i = 0; i < eff; i++) begin
            send(rand_op(), rand_op(), (i == 0) ? LW'(vl) : LW'($urandom_range(0, 7)),
                 i == 0, i == eff - 1, lat);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d products outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, W'(out_valid_w | out_valid_s), W'(0));
        check({tag, "_out_data_w"}, out_data_w, W'(0));
        check({tag, "_out_data_s"}, out_data_s, W'(0));
        check({tag, "_first"}, W'(out_first_w | out_first_s), W'(0));
        check({tag, "_last"}, W'(out_last_w | out_last_s), W'(0));
        check({tag, "_vec_done"}, W'(vec_done_w | vec_done_s), W'(0));
        check({tag, "_in_ready_w"}, W'(in_ready_w), W'(1));
        check({tag, "_in_ready_s"}, W'(in_ready_s), W'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int d0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Three-element vector, no stall, fixed latency.
        d0 = done_cnt;
        send(32'd2, 32'd3, 16'd3, 1'b1, 1'b0, 1'b1);
        send(32'd4, 32'd5, 16'd3, 1'b0, 1'b0, 1'b1);
        send(32'hFFFF_FFFF, 32'd7, 16'd3, 1'b0, 1'b1, 1'b1);
        drain();
        check("vec3_done_pulses", W'(done_cnt - d0), W'(1));

        // Single-element vectors: len 1 and len 0.
        send(32'd9, 32'd9, 16'd1, 1'b1, 1'b1, 1'b1);
        send(32'd9, 32'd9, 16'd0, 1'b1, 1'b1, 1'b1);
        drain();

        // Three-cycle downstream stall in the middle of a vector.
        fork
            send_vec(6, 1'b0, 1'b0);
            begin
                repeat (3) @(posedge clk);
                force_stall = 1'b1;
                repeat (3) @(posedge clk);
                force_stall = 1'b0;
            end
        join
        drain();

        // Saturation corners.
        send(32'h7FFF_FFFF, 32'd2, 16'd1, 1'b1, 1'b1, 1'b1);
        send(32'h8000_0000, 32'd2, 16'd1, 1'b1, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 16'd1, 1'b1, 1'b1, 1'b1);
        send(32'h8000_0000, 32'hFFFF_FFFF, 16'd1, 1'b1, 1'b1, 1'b1);
        drain();

        // Back-to-back length-2 vectors with continuous valid.
        d0 = done_cnt;
        send(rand_op(), rand_op(), 16'd2, 1'b1, 1'b0, 1'b1);
        send(rand_op(), rand_op(), 16'd5, 1'b0, 1'b1, 1'b1);
        send(rand_op(), rand_op(), 16'd2, 1'b1, 1'b0, 1'b1);
        send(rand_op(), rand_op(), 16'd7, 1'b0, 1'b1, 1'b1);
        drain();
        check("b2b_done_pulses", W'(done_cnt - d0), W'(2));

        // Reset after the first of four elements, with that product on the output.
        send(32'd3, 32'd4, 16'd4, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        d0 = done_cnt;
        send(32'd5, 32'hFFFF_FFFD, 16'd2, 1'b1, 1'b0, 1'b1);
        send(32'd6, 32'd6, 16'd3, 1'b0, 1'b1, 1'b1);
        drain();
        check("post_reset_done_pulses", W'(done_cnt - d0), W'(1));

        // Random vectors under random backpressure and input gaps.
        bp_mode = 1'b1;
        for (int v = 0; v < 30; v++) begin
            send_vec($urandom_range(0, 5), 1'b0, 1'b1);
        end
        drain();
        bp_mode = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1);
    end

endmodule
